queue_reader: RTL and testbench
===============================

QUEUE_READER -- requirements
Module: queue_reader

Interface
REQ-001 Parameter: WIDTH, 16, data word width; SHALL match the queue data width.
REQ-002 Parameter: BUF_DEPTH, 2, output buffer entries; SHALL be fixed at 2 and not overridden.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: enable  input  1  high permits new queue reads.
REQ-006 Port: q_empty  input  1  queue empty flag, valid in the current cycle.
REQ-007 Port: q_dout  input  WIDTH  queue read data, valid the cycle after a read pulse.
REQ-008 Port: q_read  output  1  single-cycle read strobe to the queue.
REQ-009 Port: m_valid  output  1  downstream data valid.
REQ-010 Port: m_ready  input  1  downstream accept.
REQ-011 Port: m_data  output  WIDTH  downstream data, the oldest buffered word.
REQ-012 Port: busy  output  1  high when state is not IDLE, the buffer is occupied, or a read is in flight.
REQ-013 Port: words_read  output  16  count of words delivered downstream.

Function
REQ-014 Block SHALL drain a queue with 1-cycle registered read latency and present the words on a valid/ready stream in FIFO order.
REQ-015 Internals SHALL be: in-flight flag `inflight` (set the cycle after q_read); 2-entry buffer with occupancy `occ` (0..2).
REQ-016 pop SHALL be defined as m_valid & m_ready; m_valid SHALL equal (occ != 0).
REQ-017 q_read SHALL assert only when: state == RUN, enable = 1, q_empty = 0, and occ + inflight - pop < 2.
   - m_ready to q_read combinational path is permitted.
   - q_read SHALL never assert while q_empty = 1.
REQ-018 When inflight = 1, q_dout SHALL be written into the buffer at that clock edge.
   - Simultaneous capture and pop SHALL leave occ unchanged and order preserved.
REQ-019 Sustained throughput with m_ready = 1 and a non-empty queue SHALL be one word per cycle.
   - First m_valid SHALL occur 2 cycles after the first q_read.
REQ-020 m_data and m_valid SHALL stay stable while m_valid = 1 and m_ready = 0.
REQ-021 FSM SHALL have exactly three states:
   - IDLE: enable = 1 moves to RUN.
   - RUN: enable = 0 moves to DRAIN.
   - DRAIN: no reads issued; moves to IDLE when inflight = 0 and occ = 0; enable = 1 returns to RUN.
REQ-022 words_read SHALL increment on each pop and wrap from 0xFFFF to 0x0000.
REQ-023 The queue going empty mid-burst SHALL stop reads without error; reads SHALL resume when q_empty returns to 0.
REQ-024 Buffer overflow SHALL be impossible by construction.
   - Bench SHALL flag any capture while occ = 2 and pop = 0.

Reset
REQ-025 While reset = 0, the following SHALL hold:
   - state IDLE;
   - occ 0, inflight 0;
   - q_read 0, m_valid 0, m_data 0;
   - words_read 0, busy 0.
REQ-026 Reset asserted mid-transfer SHALL discard buffered and in-flight data.
   - No q_read SHALL assert in the first cycle after reset deassertion.

Structure
REQ-027 Shared package SHALL hold: the state encoding (IDLE, RUN, DRAIN) and the BUF_DEPTH constant.
REQ-028 The 2-entry buffer SHALL be a sub-module named reader_skid_buf.
   - Ports: clk, reset, push, push_data, pop, data, occ.

Verification
REQ-029 Scenario: queue holds 0x0001..0x0004, enable = 1, m_ready = 1 -> q_read on 4 consecutive cycles; m_data 0x0001..0x0004 on consecutive cycles; words_read = 4; busy falls after.
REQ-030 Scenario: queue holds 5 words, m_ready = 0 -> exactly 2 q_read pulses; occ = 2; m_data holds 0x0001; releasing m_ready drains all 5 in order.
REQ-031 Scenario: q_empty = 1 throughout, enable = 1 -> q_read never asserts; m_valid = 0; busy = 1 (RUN state).
REQ-032 Scenario: enable drops with 1 word in flight and 1 buffered -> state DRAIN; both words delivered; then IDLE and busy = 0.
REQ-033 Scenario: reset pulsed low with occ = 2 -> m_valid = 0 and words_read = 0 immediately; no stale data after release.
REQ-034 Scenario: words_read preloaded near wrap via 65537 pops -> counter reads 0x0001.

Source files
------------

// File: rtl/queue_reader_pkg.sv
// -----------------------------------------------------------------------------
// queue_reader_pkg
//   Shared definitions for the queue reader block.
//   - state_t    : controller state encoding (IDLE / RUN / DRAIN)
//   - BUF_DEPTH  : number of entries in the output skid buffer (fixed at 2)
//   - OCC_W      : width of the buffer occupancy count (0..BUF_DEPTH)
//   - pending_fits: helper that decides whether one more read can be issued
//                   without the buffer overflowing when its data lands.
// -----------------------------------------------------------------------------
package queue_reader_pkg;

    localparam int BUF_DEPTH = 2;
    localparam int OCC_W     = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Words already committed to the buffer (occupied entries plus a word
    // still in flight from the queue), less the word leaving this cycle,
    // must stay below the buffer depth for one more read to be safe.
    function automatic logic pending_fits(input logic [OCC_W-1:0] occ,
                                          input logic             inflight,
                                          input logic             pop);
        logic [2:0] committed;
        logic [2:0] limit;
        committed = {1'b0, occ} + {2'b00, inflight};
        limit     = 3'(BUF_DEPTH) + {2'b00, pop};
        return (committed < limit);
    endfunction

endpackage

// File: rtl/reader_skid_buf.sv
// -----------------------------------------------------------------------------
// reader_skid_buf
//   Two-entry FIFO sitting between the queue read port and the downstream
//   stream. Entry 0 is always the oldest word and drives `data` directly, so
//   the downstream sees a registered output with no read mux.
//
//   Ports
//     clk        in   clock, rising edge
//     reset      in   asynchronous, active-low reset; empties the buffer
//     push       in   write push_data at this edge
//     push_data  in   WIDTH word to store
//     pop        in   drop the oldest word at this edge (ignored when empty)
//     data       out  oldest stored word
//     occ        out  number of stored words (0..BUF_DEPTH)
//
//   The caller guarantees no push while full without a simultaneous pop; a
//   push that would overflow is dropped rather than corrupting entry order.
// -----------------------------------------------------------------------------
module reader_skid_buf
    import queue_reader_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] data,
    output logic [OCC_W-1:0] occ
);

    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(BUF_DEPTH);

    logic [WIDTH-1:0] entry0;
    logic [WIDTH-1:0] entry1;
    logic             do_pop;

    // A pop against an empty buffer has nothing to remove.
    assign do_pop = pop && (occ != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            entry0 <= '0;
            entry1 <= '0;
            occ    <= '0;
        end else begin
            unique case ({push, do_pop})
                2'b10: begin
                    if (occ == '0) begin
                        entry0 <= push_data;
                        occ    <= occ + 1'b1;
                    end else if (occ == OCC_W'(1)) begin
                        entry1 <= push_data;
                        occ    <= occ + 1'b1;
                    end
                end
                2'b01: begin
                    entry0 <= entry1;
                    occ    <= occ - 1'b1;
                end
                2'b11: begin
                    // Occupancy is unchanged; the new word goes behind
                    // whatever survives the pop so order is preserved.
                    if (occ == OCC_FULL) begin
                        entry0 <= entry1;
                        entry1 <= push_data;
                    end else begin
                        entry0 <= push_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign data = entry0;

endmodule

// File: rtl/queue_reader.sv
// -----------------------------------------------------------------------------
// queue_reader
//   Drains a synchronous queue with one-cycle registered read latency and
//   presents the words, in order, on a valid/ready stream.
//
//   Ports
//     clk          in   clock, rising edge
//     reset        in   asynchronous, active-low reset
//     enable       in   high permits new queue reads
//     q_empty      in   queue empty flag for the current cycle
//     q_dout       in   queue data, valid the cycle after q_read
//     q_read       out  one-cycle read strobe to the queue
//     m_valid      out  downstream word available
//     m_ready      in   downstream accepts the word
//     m_data       out  oldest buffered word
//     busy         out  state not IDLE, buffer occupied or read in flight
//     words_read   out  16-bit wrapping count of words delivered downstream
//     dbg_state    out  controller state
//     dbg_occ      out  skid buffer occupancy
//     dbg_inflight out  a queue read issued last cycle is landing this edge
//
//   Stream handshake: a word transfers on every rising edge where m_valid and
//   m_ready are both high. m_valid never depends on m_ready, and once m_valid
//   is high it and m_data hold until that transfer happens.
//
//   q_read looks at m_ready combinationally so a word leaving the buffer
//   frees room for a read in the same cycle; this is what sustains one word
//   per cycle with only two buffer entries.
// -----------------------------------------------------------------------------
module queue_reader
    import queue_reader_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             q_empty,
    input  logic [WIDTH-1:0] q_dout,
    output logic             q_read,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             busy,
    output logic [15:0]      words_read,
    output state_t           dbg_state,
    output logic [OCC_W-1:0] dbg_occ,
    output logic             dbg_inflight
);

    state_t           state;
    logic             inflight;
    logic [OCC_W-1:0] occ;
    logic             pop;
    logic             room;

    assign m_valid = (occ != '0);
    assign pop     = m_valid && m_ready;
    assign room    = pending_fits(occ, inflight, pop);

    // Reads happen only in RUN. The enable term matters on the cycle enable
    // falls: the state is still RUN but no further reads should go out.
    assign q_read  = (state == ST_RUN) && enable && !q_empty && room;

    // The word requested last cycle is on q_dout now; capture it.
    reader_skid_buf #(
        .WIDTH (WIDTH)
    ) u_skid_buf (
        .clk       (clk),
        .reset     (reset),
        .push      (inflight),
        .push_data (q_dout),
        .pop       (pop),
        .data      (m_data),
        .occ       (occ)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            inflight   <= 1'b0;
            words_read <= '0;
        end else begin
            inflight <= q_read;
            if (pop) begin
                words_read <= words_read + 16'd1;
            end
            unique case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Re-enabling wins over finishing the drain so a short
                    // enable glitch does not bounce through IDLE.
                    if (enable) begin
                        state <= ST_RUN;
                    end else if (!inflight && (occ == '0)) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy         = (state != ST_IDLE) || (occ != '0) || inflight;
    assign dbg_state    = state;
    assign dbg_occ      = occ;
    assign dbg_inflight = inflight;

endmodule

// File: tb/tb_queue_reader.sv
module tb_queue_reader;
  import queue_reader_pkg::*;

  localparam int WIDTH = 16;
  localparam int SRC_N = 4096;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic             enable = 1'b0;
  logic             m_ready = 1'b0;
  logic             q_empty;
  logic [WIDTH-1:0] q_dout;
  logic             q_read;
  logic             m_valid;
  logic [WIDTH-1:0] m_data;
  logic             busy;
  logic [15:0]      words_read;
  state_t           dbg_state;
  logic [1:0]       dbg_occ;
  logic             dbg_inflight;

  queue_reader #(.WIDTH(WIDTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .q_empty      (q_empty),
    .q_dout       (q_dout),
    .q_read       (q_read),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_data       (m_data),
    .busy         (busy),
    .words_read   (words_read),
    .dbg_state    (dbg_state),
    .dbg_occ      (dbg_occ),
    .dbg_inflight (dbg_inflight)
  );

  // ---------------- checking ----------------
  int n_total = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // ---------------- queue source model ----------------
  // Words are handed out in index order; data appears one cycle after q_read.
  logic [WIDTH-1:0] src_mem[SRC_N];
  int src_len = 0;
  int rd_idx;
  assign q_empty = (rd_idx >= src_len);

  // ---------------- reference model / scoreboard ----------------
  // Every word handed out by the source is owed downstream in the same order.
  // rd_cnt   : reads issued up to the last edge
  // rd_cnt_d : reads issued up to the edge before that (their data has landed)
  // pop_cnt  : words accepted downstream
  logic [WIDTH-1:0] exp_q[$];
  int rd_cnt, rd_cnt_d, pop_cnt;
  int outstanding, buffered;
  logic popped;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_idx <= 0;
      q_dout <= '0;
      rd_cnt = 0;
      rd_cnt_d = 0;
      pop_cnt = 0;
      exp_q.delete();
    end else begin
      popped = m_valid && m_ready;
      outstanding = rd_cnt - pop_cnt;
      buffered = rd_cnt_d - pop_cnt;
      if (popped) begin
        if (exp_q.size() == 0) check_eq("pop_without_data", 1, 0);
        else check_eq("m_data_pop", m_data, exp_q.pop_front());
      end
      // A word lands this edge if a read went out last cycle.
      if ((rd_cnt != rd_cnt_d) && (buffered == 2) && !popped)
        check_eq("overflow_capture", 1, 0);
      if (q_read) begin
        check_eq("rd_while_empty", q_empty, 0);
        check_eq("rd_while_disabled", enable, 1);
        check_eq("rd_room", ((outstanding - int'(popped)) < 2), 1);
        exp_q.push_back(src_mem[rd_idx % SRC_N]);
        q_dout <= src_mem[rd_idx % SRC_N];
        rd_idx <= rd_idx + 1;
      end
      rd_cnt_d = rd_cnt;
      rd_cnt = rd_cnt + int'(q_read);
      pop_cnt = pop_cnt + int'(popped);
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      check_eq("m_valid", m_valid, ((rd_cnt_d - pop_cnt) != 0));
      if (m_valid && exp_q.size() > 0) check_eq("m_data_head", m_data, exp_q[0]);
      check_eq("words_read", words_read, pop_cnt[15:0]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    reset = 1'b0;
    enable = 1'b0;
    m_ready = 1'b0;
    src_len = 0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic load_seq(input int n, input int first);
    for (int i = 0; i < n; i++) begin
      src_mem[src_len % SRC_N] = WIDTH'(first + i);
      src_len++;
    end
  endtask

  task automatic load_rand(input int n);
    for (int i = 0; i < n; i++) begin
      src_mem[src_len % SRC_N] = WIDTH'($urandom);
      src_len++;
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("idle_timeout", busy, 0);
  endtask

  task automatic wait_pops(input int target, input int budget);
    int n = 0;
    while (pop_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("pop_timeout", pop_cnt, target);
  endtask

  initial begin
    #200000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int first_rd, last_rd, nrd, first_v, last_v, nv, loaded;

  initial begin
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_q_read", q_read, 0);
    check_eq("rst_m_valid", m_valid, 0);
    check_eq("rst_m_data", m_data, 0);
    check_eq("rst_words_read", words_read, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_state", dbg_state, ST_IDLE);
    check_eq("rst_occ", dbg_occ, 0);
    check_eq("rst_inflight", dbg_inflight, 0);
    reset = 1'b1;
    @(negedge clk);

    // Four-word burst at full rate.
    do_reset();
    load_seq(4, 1);
    m_ready = 1'b1;
    enable = 1'b1;
    first_rd = -1; last_rd = -1; nrd = 0; first_v = -1; last_v = -1; nv = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (q_read) begin
        if (first_rd < 0) first_rd = i;
        last_rd = i;
        nrd++;
      end
      if (m_valid) begin
        if (first_v < 0) first_v = i;
        last_v = i;
        nv++;
      end
    end
    check_eq("burst_first_rd", first_rd, 1);
    check_eq("burst_last_rd", last_rd, 4);
    check_eq("burst_n_rd", nrd, 4);
    check_eq("burst_first_valid", first_v, 3);
    check_eq("burst_last_valid", last_v, 6);
    check_eq("burst_n_valid", nv, 4);
    enable = 1'b0;
    wait_idle(20);
    check_eq("burst_words", words_read, 4);

    // Backpressure: buffer fills to two and holds the oldest word.
    do_reset();
    load_seq(5, 1);
    enable = 1'b1;
    nrd = 0;
    repeat (10) begin
      @(negedge clk);
      nrd += int'(q_read);
    end
    check_eq("bp_n_rd", nrd, 2);
    check_eq("bp_occ", dbg_occ, 2);
    check_eq("bp_valid", m_valid, 1);
    check_eq("bp_data", m_data, 16'h0001);
    m_ready = 1'b1;
    wait_pops(5, 40);
    enable = 1'b0;
    wait_idle(20);
    check_eq("bp_words", words_read, 5);

    // Empty queue while enabled.
    do_reset();
    enable = 1'b1;
    m_ready = 1'b1;
    nrd = 0;
    repeat (8) begin
      @(negedge clk);
      nrd += int'(q_read);
    end
    check_eq("empty_n_rd", nrd, 0);
    check_eq("empty_valid", m_valid, 0);
    check_eq("empty_busy", busy, 1);
    check_eq("empty_state", dbg_state, ST_RUN);
    enable = 1'b0;
    wait_idle(20);

    // Enable drops with one word buffered and one in flight.
    do_reset();
    load_rand(4);
    enable = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("drain_occ", dbg_occ, 1);
    check_eq("drain_inflight", dbg_inflight, 1);
    enable = 1'b0;
    @(negedge clk);
    check_eq("drain_state", dbg_state, ST_DRAIN);
    check_eq("drain_no_rd", q_read, 0);
    m_ready = 1'b1;
    wait_idle(20);
    check_eq("drain_pops", pop_cnt, 2);
    check_eq("drain_idle", dbg_state, ST_IDLE);
    check_eq("drain_words", words_read, 2);

    // Reset in the middle of a transfer with a full buffer.
    do_reset();
    load_rand(6);
    enable = 1'b1;
    repeat (5) @(negedge clk);
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("mid_occ", dbg_occ, 2);
    check_eq("mid_words", words_read, 1);
    reset = 1'b0;
    #1;
    check_eq("mid_rst_valid", m_valid, 0);
    check_eq("mid_rst_words", words_read, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_occ", dbg_occ, 0);
    src_len = 0;
    repeat (2) @(negedge clk);
    load_rand(3);
    reset = 1'b1;
    #1;
    check_eq("post_rst_no_rd", q_read, 0);
    @(negedge clk);
    check_eq("post_rst_rd", q_read, 1);
    m_ready = 1'b1;
    wait_pops(3, 30);
    enable = 1'b0;
    wait_idle(20);
    check_eq("post_rst_words", words_read, 3);

    // Random traffic: bursty queue, random backpressure and enable.
    do_reset();
    loaded = 10;
    load_rand(10);
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      m_ready = 1'($urandom_range(0, 1));
      enable = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 11) == 0 && loaded < 80) begin
        nrd = $urandom_range(1, 5);
        load_rand(nrd);
        loaded += nrd;
      end
    end
    enable = 1'b1;
    m_ready = 1'b1;
    wait_pops(loaded, 300);
    enable = 1'b0;
    wait_idle(20);

    // Counter wrap over a long full-rate run.
    do_reset();
    load_rand(SRC_N);
    src_len = 70000;
    enable = 1'b1;
    m_ready = 1'b1;
    wait_pops(65536, 66000);
    check_eq("wrap_zero", words_read, 16'h0000);
    wait_pops(65537, 10);
    check_eq("wrap_one", words_read, 16'h0001);
    enable = 1'b0;
    wait_idle(20);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
